// File: rtl/risc_pkg.sv
// Shared definitions for the KGP-RISC run controller: state encoding and
// the default sequencing constants used by the top level and its bench.
package risc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESET = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } run_state_e;

    localparam int unsigned DEF_RST_CYCLES = 2;
    localparam int unsigned DEF_MAX_CYCLES = 134;
    localparam int unsigned DEF_CNT_W      = 32;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating, clearable up-counter with a terminal-match flag that fires on
// the enabled cycle whose increment lands exactly on TERM.
module run_cycle_counter #(
    parameter int unsigned    W    = 32,
    parameter logic [W-1:0]   TERM = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o,
    output logic         tc_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic         at_max;

    assign at_max = (q_q == '1);

    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = '0;
        end else if (en_i && !at_max) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    // A TERM of zero can never be reached by a saturating increment.
    assign tc_o = en_i && !clr_i && !at_max && ((q_q + W'(1)) == TERM);
    assign q_o  = q_q;

endmodule

// File: rtl/risc_run_ctrl.sv
// Run controller for the KGP-RISC core: stretched core reset, free-run or
// single-step clock enable, halt detection and an enabled-cycle watchdog.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | core held in reset, waiting for start
// ST_RESET | core reset stretched for RST_CYCLES cycles
// ST_RUN   | core released; enabled every cycle or one cycle per step
// ST_DONE  | run ended by halt or watchdog; core state kept for inspection
module risc_run_ctrl
    import risc_pkg::*;
#(
    parameter int unsigned RST_CYCLES = DEF_RST_CYCLES,
    parameter int unsigned MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             step_mode_i,
    input  logic             step_i,
    input  logic             halt_in_i,
    output logic             cpu_rst_o,
    output logic             cpu_en_o,
    output logic             running_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] cycle_count_o
);

    localparam logic [CNT_W-1:0] RST_TERM = CNT_W'(RST_CYCLES);
    localparam logic [CNT_W-1:0] MAX_TERM = CNT_W'(MAX_CYCLES);

    run_state_e state_q, state_d;
    logic       cpu_rst_q, cpu_rst_d;
    logic       cpu_en_q, cpu_en_d;
    logic       running_q, running_d;
    logic       done_q, done_d;
    logic       timeout_q, timeout_d;

    logic             start_go;
    logic             halt_hit;
    logic             wd_tc;
    logic             wd_hit;
    logic             rst_tc;
    logic             rst_exit;
    logic             step_grant;
    logic [CNT_W-1:0] rst_cnt;

    assign start_go   = start_i && !abort_i &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign halt_hit   = cpu_en_q && halt_in_i;
    assign wd_hit     = (MAX_CYCLES != 0) && wd_tc;
    assign step_grant = (state_q == ST_RUN) && step_i && !cpu_en_q;

    // The >= guard keeps a zero RST_CYCLES from trapping the FSM in ST_RESET.
    assign rst_exit = rst_tc || (rst_cnt >= RST_TERM);

    run_cycle_counter #(
        .W    (CNT_W),
        .TERM (MAX_TERM)
    ) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_go),
        .en_i  (cpu_en_q),
        .q_o   (cycle_count_o),
        .tc_o  (wd_tc)
    );

    run_cycle_counter #(
        .W    (CNT_W),
        .TERM (RST_TERM)
    ) u_rst_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (start_go),
        .en_i  (state_q == ST_RESET),
        .q_o   (rst_cnt),
        .tc_o  (rst_tc)
    );

    always_comb begin
        state_d = state_q;

        case (state_q)
            ST_IDLE: begin
                if (start_go) state_d = ST_RESET;
            end
            ST_RESET: begin
                if (rst_exit) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (halt_hit || wd_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_go) state_d = ST_RESET;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i) state_d = ST_IDLE;

        cpu_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        cpu_en_d  = (state_d == ST_RUN) && (!step_mode_i || step_grant);

        // Halt outranks the watchdog when both land on the same enabled cycle.
        timeout_d = 1'b0;
        if (state_d == ST_DONE) begin
            timeout_d = (state_q == ST_DONE) ? timeout_q : (wd_hit && !halt_hit);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign cpu_rst_o = cpu_rst_q;
    assign cpu_en_o  = cpu_en_q;
    assign running_o = running_q;
    assign done_o    = done_q;
    assign timeout_o = timeout_q;

endmodule
